// File: rtl/id_exe_stage_reg_if.sv
// ID->EXE stage register bus: ID-side inputs, EXE-side registered outputs.
// Optional forwarding indices src1/src2 exist only when FORWARD_SRC_EN is defined.
interface id_exe_stage_reg_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 4
);
    logic              freeze;
    logic              flush;
    logic              valid_in;
    logic              WB_EN_in;
    logic              MEM_R_EN_in;
    logic              MEM_W_EN_in;
    logic [3:0]        EXE_CMD_in;
    logic              B_in;
    logic              S_in;
    logic              imm_in;
    logic [XLEN-1:0]   PC_in;
    logic [XLEN-1:0]   Val_Rn_in;
    logic [XLEN-1:0]   Val_Rm_in;
    logic [11:0]       Shift_operand_in;
    logic [23:0]       Signed_imm_24_in;
    logic [REG_AW-1:0] Dest_in;
    logic [3:0]        SR_in;

    logic              valid_out;
    logic              WB_EN_out;
    logic              MEM_R_EN_out;
    logic              MEM_W_EN_out;
    logic [3:0]        EXE_CMD_out;
    logic              B_out;
    logic              S_out;
    logic              imm_out;
    logic [XLEN-1:0]   PC_out;
    logic [XLEN-1:0]   Val_Rn_out;
    logic [XLEN-1:0]   Val_Rm_out;
    logic [11:0]       Shift_operand_out;
    logic [23:0]       Signed_imm_24_out;
    logic [REG_AW-1:0] Dest_out;
    logic [3:0]        SR_out;
    logic              LoS_out;
`ifdef FORWARD_SRC_EN
    logic [REG_AW-1:0] src1_in;
    logic [REG_AW-1:0] src2_in;
    logic [REG_AW-1:0] src1_out;
    logic [REG_AW-1:0] src2_out;
`endif

    // ID side drives the *_in fields and stall/flush controls.
    modport master (
        output freeze, flush, valid_in, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, EXE_CMD_in,
               B_in, S_in, imm_in, PC_in, Val_Rn_in, Val_Rm_in, Shift_operand_in,
               Signed_imm_24_in, Dest_in, SR_in,
`ifdef FORWARD_SRC_EN
               src1_in, src2_in,
               input src1_out, src2_out,
`endif
        input  valid_out, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, EXE_CMD_out, B_out,
               S_out, imm_out, PC_out, Val_Rn_out, Val_Rm_out, Shift_operand_out,
               Signed_imm_24_out, Dest_out, SR_out, LoS_out
    );

    // The stage register consumes *_in and presents *_out to EXE.
    modport slave (
        input  freeze, flush, valid_in, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, EXE_CMD_in,
               B_in, S_in, imm_in, PC_in, Val_Rn_in, Val_Rm_in, Shift_operand_in,
               Signed_imm_24_in, Dest_in, SR_in,
`ifdef FORWARD_SRC_EN
               src1_in, src2_in,
               output src1_out, src2_out,
`endif
        output valid_out, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, EXE_CMD_out, B_out,
               S_out, imm_out, PC_out, Val_Rn_out, Val_Rm_out, Shift_operand_out,
               Signed_imm_24_out, Dest_out, SR_out, LoS_out
    );
endinterface

// File: rtl/id_exe_stage_reg.sv
// ID->EXE pipeline register: one-cycle capture with rst > flush > freeze > load priority.
// Optional feature macro: FORWARD_SRC_EN adds src1/src2 register indices for forwarding.
module id_exe_stage_reg #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 4
) (
    input  logic               clk,
    input  logic               rst,
    id_exe_stage_reg_if.slave  bus
);
    typedef struct packed {
        logic              valid;
        logic              wb_en;
        logic              mem_r_en;
        logic              mem_w_en;
        logic [3:0]        exe_cmd;
        logic              b;
        logic              s;
        logic              los;
        logic              imm;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   val_rn;
        logic [XLEN-1:0]   val_rm;
        logic [11:0]       shift_op;
        logic [23:0]       simm24;
        logic [REG_AW-1:0] dest;
        logic [3:0]        sr;
`ifdef FORWARD_SRC_EN
        logic [REG_AW-1:0] src1;
        logic [REG_AW-1:0] src2;
`endif
    } stage_t;

    stage_t stage_q;
    stage_t stage_d;

    // Next-stage contents: bubble on flush, hold on freeze, otherwise capture ID.
    always_comb begin
        stage_d = stage_q;
        if (bus.flush) begin
            stage_d = '0;
        end else if (!bus.freeze) begin
            stage_d.valid    = bus.valid_in;
            stage_d.wb_en    = bus.WB_EN_in;
            stage_d.mem_r_en = bus.MEM_R_EN_in;
            stage_d.mem_w_en = bus.MEM_W_EN_in;
            stage_d.exe_cmd  = bus.EXE_CMD_in;
            stage_d.b        = bus.B_in;
            stage_d.s        = bus.S_in;
            stage_d.los      = bus.MEM_R_EN_in | bus.MEM_W_EN_in;
            stage_d.imm      = bus.imm_in;
            stage_d.pc       = bus.PC_in;
            stage_d.val_rn   = bus.Val_Rn_in;
            stage_d.val_rm   = bus.Val_Rm_in;
            stage_d.shift_op = bus.Shift_operand_in;
            stage_d.simm24   = bus.Signed_imm_24_in;
            stage_d.dest     = bus.Dest_in;
            stage_d.sr       = bus.SR_in;
`ifdef FORWARD_SRC_EN
            stage_d.src1     = bus.src1_in;
            stage_d.src2     = bus.src2_in;
`endif
            // An empty ID slot still carries its data but must not act in EXE.
            if (!bus.valid_in) begin
                stage_d.valid    = 1'b0;
                stage_d.wb_en    = 1'b0;
                stage_d.mem_r_en = 1'b0;
                stage_d.mem_w_en = 1'b0;
                stage_d.exe_cmd  = 4'b0000;
                stage_d.b        = 1'b0;
                stage_d.s        = 1'b0;
                stage_d.los      = 1'b0;
            end
        end
    end

    // Stage register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign bus.valid_out         = stage_q.valid;
    assign bus.WB_EN_out         = stage_q.wb_en;
    assign bus.MEM_R_EN_out      = stage_q.mem_r_en;
    assign bus.MEM_W_EN_out      = stage_q.mem_w_en;
    assign bus.EXE_CMD_out       = stage_q.exe_cmd;
    assign bus.B_out             = stage_q.b;
    assign bus.S_out             = stage_q.s;
    assign bus.LoS_out           = stage_q.los;
    assign bus.imm_out           = stage_q.imm;
    assign bus.PC_out            = stage_q.pc;
    assign bus.Val_Rn_out        = stage_q.val_rn;
    assign bus.Val_Rm_out        = stage_q.val_rm;
    assign bus.Shift_operand_out = stage_q.shift_op;
    assign bus.Signed_imm_24_out = stage_q.simm24;
    assign bus.Dest_out          = stage_q.dest;
    assign bus.SR_out            = stage_q.sr;
`ifdef FORWARD_SRC_EN
    assign bus.src1_out          = stage_q.src1;
    assign bus.src2_out          = stage_q.src2;
`endif
endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Randomized self-checking bench for id_exe_stage_reg against a field-level reference model.
module tb_id_exe_stage_reg;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 4;

    typedef struct {
        logic              valid, wb, mr, mw, b, s, imm, los;
        logic [3:0]        cmd;
        logic [XLEN-1:0]   pc, rn, rm;
        logic [11:0]       shop;
        logic [23:0]       simm;
        logic [REG_AW-1:0] dest;
        logic [3:0]        sr;
        logic [REG_AW-1:0] src1, src2;
    } rec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    rec_t stim;
    rec_t expv;
    logic freeze_v, flush_v;

    id_exe_stage_reg_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus ();

    id_exe_stage_reg #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.freeze           = freeze_v;
    assign bus.flush            = flush_v;
    assign bus.valid_in         = stim.valid;
    assign bus.WB_EN_in         = stim.wb;
    assign bus.MEM_R_EN_in      = stim.mr;
    assign bus.MEM_W_EN_in      = stim.mw;
    assign bus.EXE_CMD_in       = stim.cmd;
    assign bus.B_in             = stim.b;
    assign bus.S_in             = stim.s;
    assign bus.imm_in           = stim.imm;
    assign bus.PC_in            = stim.pc;
    assign bus.Val_Rn_in        = stim.rn;
    assign bus.Val_Rm_in        = stim.rm;
    assign bus.Shift_operand_in = stim.shop;
    assign bus.Signed_imm_24_in = stim.simm;
    assign bus.Dest_in          = stim.dest;
    assign bus.SR_in            = stim.sr;
`ifdef FORWARD_SRC_EN
    assign bus.src1_in          = stim.src1;
    assign bus.src2_in          = stim.src2;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic rec_t zero_rec();
        rec_t z;
        z = '{default: '0};
        return z;
    endfunction

    // Behavioural model of one clock edge, straight from the stage rules.
    function automatic rec_t model(rec_t cur, rec_t in, logic r, logic fl, logic fz);
        rec_t n;
        if (r || fl) return zero_rec();
        if (fz) return cur;
        n = in;
        n.los = in.mr | in.mw;
`ifndef FORWARD_SRC_EN
        n.src1 = '0;
        n.src2 = '0;
`endif
        if (!in.valid) begin
            n.wb = 0; n.mr = 0; n.mw = 0; n.b = 0; n.s = 0; n.los = 0; n.cmd = 4'b0000;
        end
        return n;
    endfunction

    task automatic check_outputs(input string ph);
        chk({ph, ".valid"}, 64'(bus.valid_out),         64'(expv.valid));
        chk({ph, ".wb"},    64'(bus.WB_EN_out),         64'(expv.wb));
        chk({ph, ".mr"},    64'(bus.MEM_R_EN_out),      64'(expv.mr));
        chk({ph, ".mw"},    64'(bus.MEM_W_EN_out),      64'(expv.mw));
        chk({ph, ".cmd"},   64'(bus.EXE_CMD_out),       64'(expv.cmd));
        chk({ph, ".b"},     64'(bus.B_out),             64'(expv.b));
        chk({ph, ".s"},     64'(bus.S_out),             64'(expv.s));
        chk({ph, ".imm"},   64'(bus.imm_out),           64'(expv.imm));
        chk({ph, ".los"},   64'(bus.LoS_out),           64'(expv.los));
        chk({ph, ".pc"},    64'(bus.PC_out),            64'(expv.pc));
        chk({ph, ".rn"},    64'(bus.Val_Rn_out),        64'(expv.rn));
        chk({ph, ".rm"},    64'(bus.Val_Rm_out),        64'(expv.rm));
        chk({ph, ".shop"},  64'(bus.Shift_operand_out), 64'(expv.shop));
        chk({ph, ".simm"},  64'(bus.Signed_imm_24_out), 64'(expv.simm));
        chk({ph, ".dest"},  64'(bus.Dest_out),          64'(expv.dest));
        chk({ph, ".sr"},    64'(bus.SR_out),            64'(expv.sr));
`ifdef FORWARD_SRC_EN
        chk({ph, ".src1"},  64'(bus.src1_out),          64'(expv.src1));
        chk({ph, ".src2"},  64'(bus.src2_out),          64'(expv.src2));
`endif
    endtask

    // Advance one edge, update the model with the values present at the edge, then compare.
    task automatic step(input string ph);
        @(posedge clk);
        expv = model(expv, stim, rst, flush_v, freeze_v);
        #1;
        check_outputs(ph);
    endtask

    task automatic rand_stim();
        stim.valid = ($urandom_range(0, 3) != 0);
        stim.wb    = 1'($urandom);
        stim.mr    = 1'($urandom);
        stim.mw    = 1'($urandom);
        stim.cmd   = 4'($urandom);
        stim.b     = 1'($urandom);
        stim.s     = 1'($urandom);
        stim.imm   = 1'($urandom);
        stim.los   = 1'b0;
        stim.pc    = 32'($urandom);
        stim.rn    = 32'($urandom);
        stim.rm    = 32'($urandom);
        stim.shop  = 12'($urandom);
        stim.simm  = 24'($urandom);
        stim.dest  = 4'($urandom);
        stim.sr    = 4'($urandom);
        stim.src1  = 4'($urandom);
        stim.src2  = 4'($urandom);
    endtask

    initial begin
        expv     = zero_rec();
        // Reset held two cycles with every input high.
        stim     = '{default: '1};
        freeze_v = 1'b1;
        flush_v  = 1'b1;
        rst      = 1'b1;
        step("rst0");
        step("rst1");

        // First load right after reset release: ADD.
        rst      = 1'b0;
        freeze_v = 1'b0;
        flush_v  = 1'b0;
        rand_stim();
        stim.valid = 1; stim.mr = 0; stim.mw = 0; stim.cmd = 4'b0010;
        stim.rm = 32'h0000_00F0; stim.shop = 12'h0E2;
        step("add");

        // STR selects the offset path.
        rand_stim();
        stim.valid = 1; stim.mr = 0; stim.mw = 1; stim.shop = 12'h004;
        step("str");

        // Freeze for three cycles with changing inputs, then release.
        freeze_v = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_stim();
            step("frz");
        end
        freeze_v = 1'b0;
        rand_stim();
        step("frz_rel");

        // Flush and freeze together with a valid LDR: flush wins.
        rand_stim();
        stim.valid = 1; stim.mr = 1; stim.mw = 0; stim.cmd = 4'b0100;
        step("ldr");
        freeze_v = 1'b1;
        flush_v  = 1'b1;
        step("flfz");
        freeze_v = 1'b0;
        flush_v  = 1'b0;

        // Illegal load+store combination is captured as-is.
        rand_stim();
        stim.valid = 1; stim.mr = 1; stim.mw = 1;
        step("ldst");

        // Bubble from ID: control cleared, data captured.
        rand_stim();
        stim.valid = 0; stim.wb = 1; stim.mr = 1; stim.cmd = 4'hF;
        step("bubble");

`ifdef FORWARD_SRC_EN
        rand_stim();
        stim.valid = 1; stim.src1 = 4'd3; stim.src2 = 4'd7;
        step("fwd");
        flush_v = 1'b1;
        step("fwd_fl");
        flush_v = 1'b0;
`endif

        // Reset asserted mid-freeze.
        rand_stim();
        step("pre_rst");
        freeze_v = 1'b1;
        rst      = 1'b1;
        step("rst_frz");
        rst      = 1'b0;
        freeze_v = 1'b0;

        // Random traffic with occasional stalls, flushes and resets.
        for (int i = 0; i < 400; i++) begin
            rand_stim();
            freeze_v = ($urandom_range(0, 4) == 0);
            flush_v  = ($urandom_range(0, 9) == 0);
            rst      = ($urandom_range(0, 31) == 0);
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
